health_bar_controller: RTL and testbench

Tracks player hit points and produces the per-pixel health-bar fill and border signals that feed the universal renderer (`healt_bar_signal`, `healt_bar_border_signal`).

- Applies damage and heal events to a saturating HP register.
- Animates the displayed bar toward the true HP once per video frame.
- Blinks the border for a fixed number of frames after each hit.
- All visible state changes only at frame boundaries, so the bar never tears mid-frame.

---
 rtl/health_bar_controller_pkg.sv | 38 +++
 rtl/health_bar_controller_frame_tick_gen.sv | 27 ++
 rtl/health_bar_controller.sv | 174 +++++++++++++++++
 tb/tb_health_bar_controller.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/health_bar_controller_pkg.sv
// rtl/health_bar_controller_pkg.sv - shared screen constants, display states and step helpers
package health_bar_controller_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef enum logic [1:0] {
    STEADY   = 2'd0,
    DRAINING = 2'd1,
    FILLING  = 2'd2,
    DEAD     = 2'd3
  } disp_state_t;

  // Move cur down by step, never going below target.
  function automatic logic [7:0] step_down(input logic [7:0] cur,
                                           input logic [7:0] target,
                                           input logic [7:0] step);
    logic [8:0] floor9;
    floor9 = {1'b0, target} + {1'b0, step};
    if ({1'b0, cur} <= floor9) begin
      return target;
    end
    return cur - step;
  endfunction

  // Move cur up by step, never going above target.
  function automatic logic [7:0] step_up(input logic [7:0] cur,
                                         input logic [7:0] target,
                                         input logic [7:0] step);
    logic [8:0] sum9;
    sum9 = {1'b0, cur} + {1'b0, step};
    if (sum9 >= {1'b0, target}) begin
      return target;
    end
    return sum9[7:0];
  endfunction

endpackage

// File: rtl/health_bar_controller_frame_tick_gen.sv
// rtl/health_bar_controller_frame_tick_gen.sv - one-clk pulse when the scan enters the first blank row
module frame_tick_gen
  import health_bar_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] y,
  output logic       tick
);

  logic row_hit;
  logic row_hit_d;

  // Registered row compare plus delayed copy so a held row yields a single edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_hit   <= 1'b0;
      row_hit_d <= 1'b0;
    end else begin
      row_hit   <= (y == 10'(V_ACTIVE));
      row_hit_d <= row_hit;
    end
  end

  assign tick = row_hit & ~row_hit_d;

endmodule

// File: rtl/health_bar_controller.sv
// rtl/health_bar_controller.sv - HP register, animated health bar and blinking border decode
module health_bar_controller
  import health_bar_controller_pkg::*;
#(
  parameter int MAX_HP       = 20,
  parameter int PX_PER_HP    = 8,
  parameter int BAR_X        = 16,
  parameter int BAR_Y        = 448,
  parameter int BAR_H        = 16,
  parameter int BORDER       = 2,
  parameter int DRAIN_STEP   = 1,
  parameter int FILL_STEP    = 1,
  parameter int FLASH_FRAMES = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       blank,
  input  logic       damage_valid,
  input  logic [7:0] damage_amount,
  input  logic       heal_valid,
  input  logic [7:0] heal_amount,
  output logic       healt_bar_signal,
  output logic       healt_bar_border_signal,
  output logic [7:0] hp_value,
  output logic       hp_zero
);

  localparam logic [7:0] MAX_HP8  = 8'(MAX_HP);
  localparam logic [7:0] DRAIN8   = 8'(DRAIN_STEP);
  localparam logic [7:0] FILL8    = 8'(FILL_STEP);
  localparam logic [7:0] FLASH8   = 8'(FLASH_FRAMES);

  localparam logic [9:0] OUT_X0 = 10'(BAR_X);
  localparam logic [9:0] OUT_X1 = 10'(BAR_X + MAX_HP * PX_PER_HP + 2 * BORDER);
  localparam logic [9:0] OUT_Y0 = 10'(BAR_Y);
  localparam logic [9:0] OUT_Y1 = 10'(BAR_Y + BAR_H);
  localparam logic [9:0] IN_X0  = 10'(BAR_X + BORDER);
  localparam logic [9:0] IN_X1  = 10'(BAR_X + MAX_HP * PX_PER_HP + BORDER);
  localparam logic [9:0] IN_Y0  = 10'(BAR_Y + BORDER);
  localparam logic [9:0] IN_Y1  = 10'(BAR_Y + BAR_H - BORDER);
  localparam logic [9:0] PX10   = 10'(PX_PER_HP);

  logic        frame_tick;
  logic [7:0]  hp_q;
  logic        hp_zero_q;
  logic [7:0]  disp_q;
  logic [7:0]  disp_d;
  logic [7:0]  flash_q;
  disp_state_t state_q;
  disp_state_t state_d;

  logic [8:0]  dmg9;
  logic [8:0]  heal9;
  logic [8:0]  after_dmg9;
  logic [8:0]  sum9;
  logic [7:0]  hp_new;
  logic        hp_event;
  logic        flash_load;

  logic [7:0]  drain_val;
  logic [7:0]  fill_val;
  logic [7:0]  dead_val;

  logic        in_outer;
  logic        in_inner;
  logic        border_vis;
  logic [9:0]  fill_end;

  frame_tick_gen u_frame_tick_gen (
    .clk   (clk),
    .reset (reset),
    .y     (y),
    .tick  (frame_tick)
  );

  // Saturating HP arithmetic: subtract damage first, then add heal, clamp to MAX_HP.
  always_comb begin
    dmg9       = damage_valid ? {1'b0, damage_amount} : 9'd0;
    heal9      = heal_valid ? {1'b0, heal_amount} : 9'd0;
    after_dmg9 = ({1'b0, hp_q} > dmg9) ? ({1'b0, hp_q} - dmg9) : 9'd0;
    sum9       = after_dmg9 + heal9;
    hp_new     = (sum9 > {1'b0, MAX_HP8}) ? MAX_HP8 : sum9[7:0];
    hp_event   = (damage_valid | heal_valid) & ~hp_zero_q;
    flash_load = damage_valid & (damage_amount != 8'd0) & ~hp_zero_q;
  end

  // True HP and the latched death flag; events are ignored once dead.
  always_ff @(posedge clk) begin
    if (reset) begin
      hp_q      <= MAX_HP8;
      hp_zero_q <= 1'b0;
    end else if (hp_event) begin
      hp_q <= hp_new;
      if (hp_new == 8'd0) begin
        hp_zero_q <= 1'b1;
      end
    end
  end

  assign drain_val = step_down(disp_q, hp_q, DRAIN8);
  assign fill_val  = step_up(disp_q, hp_q, FILL8);
  assign dead_val  = step_down(disp_q, 8'd0, DRAIN8);

  // Display FSM next state: animate disp_hp toward hp once per frame tick.
  always_comb begin
    state_d = state_q;
    disp_d  = disp_q;
    if (frame_tick) begin
      if (hp_zero_q) begin
        state_d = DEAD;
        disp_d  = dead_val;
      end else begin
        case (state_q)
          STEADY, DRAINING, FILLING: begin
            if (hp_q < disp_q) begin
              disp_d  = drain_val;
              state_d = (drain_val == hp_q) ? STEADY : DRAINING;
            end else if (hp_q > disp_q) begin
              disp_d  = fill_val;
              state_d = (fill_val == hp_q) ? STEADY : FILLING;
            end else begin
              state_d = STEADY;
            end
          end
          default: begin
            state_d = DEAD;
            disp_d  = dead_val;
          end
        endcase
      end
    end
  end

  // Display FSM state register; reset snaps the bar to full.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= STEADY;
      disp_q  <= MAX_HP8;
    end else begin
      state_q <= state_d;
      disp_q  <= disp_d;
    end
  end

  // Border blink counter: reloads on any hit, counts frames, cleared for good once dead.
  always_ff @(posedge clk) begin
    if (reset) begin
      flash_q <= 8'd0;
    end else if ((state_q == DEAD) || (frame_tick && hp_zero_q)) begin
      flash_q <= 8'd0;
    end else if (flash_load) begin
      flash_q <= FLASH8;
    end else if (frame_tick && (flash_q != 8'd0)) begin
      flash_q <= flash_q - 8'd1;
    end
  end

  assign border_vis = (flash_q == 8'd0) | ~flash_q[2];
  assign fill_end   = IN_X0 + ({2'b00, disp_q} * PX10);

  // Pixel decode against the bar rectangles; blanking suppresses both outputs.
  always_comb begin
    in_outer = (x >= OUT_X0) && (x < OUT_X1) && (y >= OUT_Y0) && (y < OUT_Y1);
    in_inner = (x >= IN_X0) && (x < IN_X1) && (y >= IN_Y0) && (y < IN_Y1);
    healt_bar_signal        = ~blank & in_inner & (x < fill_end);
    healt_bar_border_signal = ~blank & in_outer & ~in_inner & border_vis;
  end

  assign hp_value = hp_q;
  assign hp_zero  = hp_zero_q;

endmodule

// File: tb/tb_health_bar_controller.sv
// tb/tb_health_bar_controller.sv - directed self-checking bench for health_bar_controller
module tb_health_bar_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x = 10'd0;
  logic [9:0] y = 10'd0;
  logic       blank = 1'b0;
  logic       damage_valid = 1'b0;
  logic [7:0] damage_amount = 8'd0;
  logic       heal_valid = 1'b0;
  logic [7:0] heal_amount = 8'd0;
  logic       healt_bar_signal;
  logic       healt_bar_border_signal;
  logic [7:0] hp_value;
  logic       hp_zero;

  int tests = 0;
  int fails = 0;
  int ticks = 0;

  health_bar_controller dut (
    .clk                     (clk),
    .reset                   (reset),
    .x                       (x),
    .y                       (y),
    .blank                   (blank),
    .damage_valid            (damage_valid),
    .damage_amount           (damage_amount),
    .heal_valid              (heal_valid),
    .heal_amount             (heal_amount),
    .healt_bar_signal        (healt_bar_signal),
    .healt_bar_border_signal (healt_bar_border_signal),
    .hp_value                (hp_value),
    .hp_zero                 (hp_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dut.frame_tick) ticks <= ticks + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pix(input int px, input int py, input logic bl);
    x = 10'(px);
    y = 10'(py);
    blank = bl;
    #1;
  endtask

  task automatic park();
    x = 10'd0;
    y = 10'd0;
    blank = 1'b0;
  endtask

  // Fill must end exactly at x = 18 + 8*disp on an inner row.
  task automatic check_disp(input string tag, input int exp_disp);
    if (exp_disp > 0) begin
      pix(18 + exp_disp * 8 - 1, 455, 1'b0);
      chk({tag, "_last_in"}, 32'(healt_bar_signal), 32'd1);
    end
    pix(18 + exp_disp * 8, 455, 1'b0);
    chk({tag, "_first_out"}, 32'(healt_bar_signal), 32'd0);
    park();
  endtask

  task automatic check_border(input string tag, input logic exp_vis);
    pix(16, 448, 1'b0);
    chk(tag, 32'(healt_bar_border_signal), 32'(exp_vis));
    park();
  endtask

  task automatic frame();
    y = 10'd480;
    repeat (4) step();
    y = 10'd0;
    repeat (4) step();
  endtask

  task automatic pulse(input logic dv, input int da, input logic hv, input int ha);
    damage_valid  = dv;
    damage_amount = 8'(da);
    heal_valid    = hv;
    heal_amount   = 8'(ha);
    step();
    damage_valid  = 1'b0;
    damage_amount = 8'd0;
    heal_valid    = 1'b0;
    heal_amount   = 8'd0;
  endtask

  function automatic logic blink_vis(input int f);
    return (f == 0) || ((f & 4) == 0);
  endfunction

  initial begin
    int t0;
    int f;
    int d;

    // Reset state
    repeat (2) step();
    reset = 1'b0;
    chk("rst_hp", 32'(hp_value), 32'd20);
    chk("rst_zero", 32'(hp_zero), 32'd0);
    check_disp("rst_disp", 20);
    check_border("rst_border", 1'b1);
    pix(17, 450, 1'b0);
    chk("rst_fill_x17", 32'(healt_bar_signal), 32'd0);
    chk("rst_border_x17", 32'(healt_bar_border_signal), 32'd1);
    pix(18, 450, 1'b0);
    chk("rst_fill_18_450", 32'(healt_bar_signal), 32'd1);
    pix(177, 461, 1'b0);
    chk("rst_fill_177_461", 32'(healt_bar_signal), 32'd1);
    pix(18, 462, 1'b0);
    chk("rst_fill_y462", 32'(healt_bar_signal), 32'd0);
    pix(18, 449, 1'b0);
    chk("rst_fill_y449", 32'(healt_bar_signal), 32'd0);
    pix(100, 455, 1'b0);
    chk("rst_border_interior", 32'(healt_bar_border_signal), 32'd0);
    pix(179, 463, 1'b0);
    chk("rst_border_corner", 32'(healt_bar_border_signal), 32'd1);
    pix(180, 463, 1'b0);
    chk("rst_border_outside", 32'(healt_bar_border_signal), 32'd0);
    park();

    // Row sweep at 2 pixels x 4 clk per row: one tick across the whole pass
    t0 = ticks;
    for (int row = 470; row <= 490; row++) begin
      y = 10'(row);
      repeat (8) step();
    end
    y = 10'd0;
    step();
    chk("sweep_one_tick", 32'(ticks - t0), 32'd1);
    t0 = ticks;
    frame();
    frame();
    chk("two_frames_two_ticks", 32'(ticks - t0), 32'd2);
    check_disp("sweep_disp", 20);

    // Damage 5 mid-frame, then drain and blink
    y = 10'd100;
    pulse(1'b1, 5, 1'b0, 0);
    chk("dmg5_hp", 32'(hp_value), 32'd15);
    check_disp("dmg5_disp_hold", 20);
    check_border("dmg5_border_pre", 1'b1);
    for (int k = 1; k <= 24; k++) begin
      frame();
      d = (20 - k > 15) ? 20 - k : 15;
      f = 24 - k;
      check_disp($sformatf("dmg5_disp_f%0d", k), d);
      check_border($sformatf("dmg5_border_f%0d", k), blink_vis(f));
    end

    // Damage 3 with heal 10 in one cycle: 15 -> 12 -> 20
    pulse(1'b1, 3, 1'b1, 10);
    chk("mix_hp", 32'(hp_value), 32'd20);
    for (int k = 1; k <= 5; k++) begin
      frame();
      check_disp($sformatf("mix_fill_f%0d", k), 15 + k);
    end
    repeat (19) frame();
    check_disp("mix_final", 20);
    check_border("mix_flash_done", 1'b1);

    // Hit during an active drain reloads the blink and retargets without overshoot
    pulse(1'b1, 10, 1'b0, 0);
    chk("drain_hp10", 32'(hp_value), 32'd10);
    frame();
    frame();
    check_disp("drain_two_frames", 18);
    pulse(1'b1, 2, 1'b0, 0);
    chk("drain_hp8", 32'(hp_value), 32'd8);
    for (int k = 1; k <= 24; k++) begin
      frame();
      d = (18 - k > 8) ? 18 - k : 8;
      f = 24 - k;
      check_disp($sformatf("redrain_disp_f%0d", k), d);
      check_border($sformatf("reflash_f%0d", k), blink_vis(f));
    end

    // Death: overkill, later events ignored, bar drains to zero, border solid
    pulse(1'b1, 4, 1'b0, 0);
    repeat (4) frame();
    check_disp("pre_death_disp", 4);
    pulse(1'b1, 200, 1'b0, 0);
    chk("death_hp", 32'(hp_value), 32'd0);
    chk("death_flag", 32'(hp_zero), 32'd1);
    pulse(1'b0, 0, 1'b1, 10);
    chk("dead_heal_ignored", 32'(hp_value), 32'd0);
    pulse(1'b1, 1, 1'b1, 5);
    chk("dead_mix_ignored", 32'(hp_value), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      frame();
      d = (4 - k > 0) ? 4 - k : 0;
      check_disp($sformatf("dead_disp_f%0d", k), d);
      check_border($sformatf("dead_border_f%0d", k), 1'b1);
    end
    chk("dead_flag_held", 32'(hp_zero), 32'd1);

    // Reset clears death, then reset again in the middle of a drain
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("revive_hp", 32'(hp_value), 32'd20);
    chk("revive_zero", 32'(hp_zero), 32'd0);
    check_disp("revive_disp", 20);
    pulse(1'b1, 10, 1'b0, 0);
    repeat (3) frame();
    check_disp("middrain_disp", 17);
    y = 10'd300;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("middrain_rst_hp", 32'(hp_value), 32'd20);
    chk("middrain_rst_zero", 32'(hp_zero), 32'd0);
    check_disp("middrain_rst_disp", 20);
    check_border("middrain_rst_border", 1'b1);
    frame();
    check_disp("middrain_rst_no_anim", 20);
    check_border("middrain_rst_border_f1", 1'b1);
    pix(100, 455, 1'b1);
    chk("blank_fill", 32'(healt_bar_signal), 32'd0);
    pix(16, 448, 1'b1);
    chk("blank_border", 32'(healt_bar_border_signal), 32'd0);
    park();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
